// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine for the LA32R core.
// Accepts one request from EX, drives an SRAM-like bus with an addr_ok/data_ok
// handshake, and returns a one-cycle response with extended load data or a
// misalignment flag. No-ops and misaligned accesses never touch the bus.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size_mem,
    input  logic        is_unsign_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_ale,
    output logic        busy,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        unsign_q, unsign_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ale_q, ale_d;

    // Request decode: effective size (3 behaves as word), lane strobes,
    // replicated store data and the alignment check on the incoming address.
    logic [1:0]  sz_eff;
    logic [3:0]  strb_in;
    logic [31:0] wdata_rep;
    logic        noop_in;
    logic        mis_in;

    // Decode the incoming request fields into bus-ready form.
    always_comb begin
        sz_eff    = (size_mem == 2'd3) ? 2'd2 : size_mem;
        strb_in   = 4'hF;
        wdata_rep = wdata;
        case (sz_eff)
            2'd0: begin
                strb_in   = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'd1: begin
                strb_in   = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                strb_in   = 4'hF;
                wdata_rep = wdata;
            end
        endcase
        noop_in = ~mem_read & ~mem_write;
        mis_in  = ((sz_eff == 2'd1) & addr[0]) |
                  ((sz_eff == 2'd2) & (addr[1:0] != 2'b00));
    end

    // Extract and extend the addressed lane of the returned word.
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_ext;

    // Pick the byte/half selected by the registered low address bits.
    always_comb begin
        lb     = data_sram_rdata[{addr_q[1:0], 3'b000} +: 8];
        lh     = data_sram_rdata[{addr_q[1], 4'b0000} +: 16];
        ld_ext = data_sram_rdata;
        case (size_q)
            2'd0:    ld_ext = {{24{~unsign_q & lb[7]}}, lb};
            2'd1:    ld_ext = {{16{~unsign_q & lh[15]}}, lh};
            default: ld_ext = data_sram_rdata;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/ADDR/DATA handshake.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unsign_d = unsign_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        ale_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (noop_in || mis_in) begin
                        // Answered locally next cycle; bus stays quiet.
                        rvalid_d = 1'b1;
                        ale_d    = ~noop_in & mis_in;
                    end else begin
                        state_d  = ADDR;
                        req_d    = 1'b1;
                        wr_d     = mem_write;
                        size_d   = sz_eff;
                        addr_d   = addr;
                        wstrb_d  = mem_write ? strb_in : 4'h0;
                        wdata_d  = wdata_rep;
                        unsign_d = is_unsign_load;
                    end
                end
            end
            ADDR: begin
                if (data_sram_addr_ok) begin
                    req_d = 1'b0;
                    if (data_sram_data_ok) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b1;
                        rdata_d  = wr_q ? 32'd0 : ld_ext;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (data_sram_data_ok) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = wr_q ? 32'd0 : ld_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'h0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            unsign_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            ale_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            unsign_q <= unsign_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ale_q    <= ale_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign resp_valid      = rvalid_q;
    assign resp_rdata      = rdata_q;
    assign resp_ale        = ale_q;
    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized requests with
// random bus wait states, checked against an arithmetic reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size_mem;
    logic        is_unsign_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_ale;
    logic        busy;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .size_mem          (size_mem),
        .is_unsign_load    (is_unsign_load),
        .addr              (addr),
        .wdata             (wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_ale          (resp_ale),
        .busy              (busy),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input int sz);
        return (sz == 3) ? 2 : sz;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input int sz, input int a, input bit u);
        logic [31:0] v;
        int s;
        s = m_size(sz);
        if (s == 0) begin
            v = (rd >> (8 * a)) & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 1) begin
            v = (rd >> (16 * (a / 2))) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_strb(input int sz, input int a, input bit wr);
        int s;
        s = m_size(sz);
        if (!wr) return 32'd0;
        if (s == 0) return 32'(1 << a);
        if (s == 1) return 32'(3 << (a & 2));
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
        int s;
        s = m_size(sz);
        if (s == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic bit m_mis(input int sz, input int a);
        int s;
        s = m_size(sz);
        if (s == 1) return (a % 2) != 0;
        if (s == 2) return a != 0;
        return 1'b0;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_ale", {31'd0, resp_ale}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_sram_req", {31'd0, data_sram_req}, 32'd0);
        chk("rst_sram_wr", {31'd0, data_sram_wr}, 32'd0);
        chk("rst_sram_size", {30'd0, data_sram_size}, 32'd0);
        chk("rst_sram_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
        chk("rst_sram_addr", data_sram_addr, 32'd0);
        chk("rst_sram_wdata", data_sram_wdata, 32'd0);
    endtask

    // One full request: present it, play the memory side with da addr_ok
    // wait cycles and dd data_ok wait cycles (or same-cycle completion), and
    // check bus fields, latency and the response against the model.
    task automatic do_req(input bit rd, input bit wr, input int sz, input bit u,
                          input logic [31:0] a, input logic [31:0] w, input logic [31:0] rdv,
                          input int da, input int dd, input bit same, input bit idle_after);
        bit noop;
        bit mis;
        int lo;
        lo   = int'(a[1:0]);
        noop = !rd && !wr;
        mis  = m_mis(sz, lo);
        chk("ready_pre", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; size_mem = 2'(sz);
        is_unsign_load = u; addr = a; wdata = w;
        tick();
        req_valid = 1'b0;
        // Scramble fields: the unit must work from what it captured.
        addr = $urandom; wdata = $urandom; size_mem = 2'($urandom_range(0, 3));
        mem_read = 1'($urandom); mem_write = 1'($urandom); is_unsign_load = 1'($urandom);
        if (noop || mis) begin
            chk("local_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("local_resp_ale", {31'd0, resp_ale}, {31'd0, mis && !noop});
            chk("local_resp_rdata", resp_rdata, 32'd0);
            chk("local_sram_req", {31'd0, data_sram_req}, 32'd0);
            chk("local_ready", {31'd0, req_ready}, 32'd1);
            chk("local_busy", {31'd0, busy}, 32'd0);
        end else begin
            for (int i = 0; i <= da; i++) begin
                chk("addr_req", {31'd0, data_sram_req}, 32'd1);
                chk("addr_addr", data_sram_addr, a);
                chk("addr_wr", {31'd0, data_sram_wr}, {31'd0, wr});
                chk("addr_size", {30'd0, data_sram_size}, 32'(m_size(sz)));
                chk("addr_wstrb", {28'd0, data_sram_wstrb}, m_strb(sz, lo, wr));
                if (wr) chk("addr_wdata", data_sram_wdata, m_wdata(sz, w));
                chk("addr_busy", {31'd0, busy}, 32'd1);
                chk("addr_ready", {31'd0, req_ready}, 32'd0);
                chk("addr_resp_valid", {31'd0, resp_valid}, 32'd0);
                if (i < da) begin
                    data_sram_addr_ok = 1'b0;
                    data_sram_data_ok = 1'($urandom);   // must be ignored without addr_ok
                    data_sram_rdata   = $urandom;
                    req_valid         = 1'($urandom);   // ignored while busy
                end else begin
                    data_sram_addr_ok = 1'b1;
                    data_sram_data_ok = same;
                    data_sram_rdata   = same ? rdv : $urandom;
                    req_valid         = 1'b0;
                end
                tick();
            end
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            if (!same) begin
                for (int j = 0; j <= dd; j++) begin
                    chk("data_req", {31'd0, data_sram_req}, 32'd0);
                    chk("data_busy", {31'd0, busy}, 32'd1);
                    chk("data_resp_valid", {31'd0, resp_valid}, 32'd0);
                    data_sram_addr_ok = 1'($urandom);
                    data_sram_data_ok = (j == dd);
                    data_sram_rdata   = (j == dd) ? rdv : $urandom;
                    req_valid         = (j == dd) ? 1'b0 : 1'($urandom);
                    tick();
                end
                data_sram_addr_ok = 1'b0;
                data_sram_data_ok = 1'b0;
            end
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_rdata", resp_rdata, wr ? 32'd0 : m_load(rdv, sz, lo, u));
            chk("resp_ale", {31'd0, resp_ale}, 32'd0);
            chk("resp_ready", {31'd0, req_ready}, 32'd1);
            chk("resp_busy", {31'd0, busy}, 32'd0);
        end
        if (idle_after) begin
            tick();
            chk("pulse_one_cycle", {31'd0, resp_valid}, 32'd0);
            chk("idle_sram_req", {31'd0, data_sram_req}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size_mem = 2'd0; is_unsign_load = 1'b0; addr = 32'd0; wdata = 32'd0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        #2;
        chk_reset_outputs();
        tick(); tick();
        #2 resetn = 1'b1;
        tick();

        // st.b at 0x1003: strobe on lane 3, byte replicated, resp at T+3
        do_req(0, 1, 0, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0, 1);
        // ld.b / ld.bu on lane 2
        do_req(1, 0, 0, 0, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, 0, 0, 1);
        do_req(1, 0, 0, 1, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, 0, 0, 1);
        // ld.h / ld.hu upper half
        do_req(1, 0, 1, 0, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 0, 1);
        do_req(1, 0, 1, 1, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 0, 1);
        // misaligned ld.w: local answer with ale
        do_req(1, 0, 2, 0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0, 1);
        // no-op
        do_req(0, 0, 2, 0, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 0, 1);
        // wait states on a half store
        do_req(0, 1, 1, 0, 32'h0000_5002, 32'h1234_BEEF, 32'h0, 3, 2, 0, 1);
        // same-cycle addr_ok/data_ok, size 3 as word, read+write is a store
        do_req(1, 0, 3, 0, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 1);
        do_req(1, 1, 2, 0, 32'h0000_7008, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, 1);
        // back-to-back: new request in the response cycle
        do_req(1, 0, 0, 0, 32'h0000_8001, 32'h0, 32'h0000_8000, 0, 0, 0, 0);
        do_req(1, 0, 0, 0, 32'h0000_8001, 32'h0, 32'h0000_8000, 0, 0, 1, 1);

        // reset while in DATA, then a stray data_ok
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size_mem = 2'd2;
        is_unsign_load = 1'b0; addr = 32'h0000_9000;
        tick();
        req_valid = 1'b0; data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 resetn = 1'b0;
        #1 chk_reset_outputs();
        @(posedge clk); #2 resetn = 1'b1;
        #1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        tick();
        data_sram_data_ok = 1'b0;
        chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("stray_resp_valid2", {31'd0, resp_valid}, 32'd0);
        do_req(1, 0, 1, 0, 32'h0000_A002, 32'h0, 32'h7FFF_0000, 1, 1, 0, 1);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                   $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
